music_sequencer: RTL and testbench

Parametrised, programmable note sequencer that drives one or more `audio_channel` instances directly. Step entries live in an internal write-port RAM. Each step sets frequency and gate for all voices for a programmed number of ticks, with automatic note-separation gaps and optional looping. It replaces hand-timed en/freq stimulus with on-chip playback. It sits between the control bus and the per-voice channel `en_i`/`freq_i` inputs.

---
 rtl/music_seq_pkg.sv | 24 ++
 rtl/seq_note_ram.sv | 23 ++
 rtl/music_sequencer.sv | 149 ++++++++++++++
 tb/tb_music_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/music_seq_pkg.sv
// rtl/music_seq_pkg.sv - state type and step-entry layout helpers for music_sequencer
package music_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } seq_state_e;

    function automatic int entry_w(input int voices, input int freq_w, input int dur_w);
        return 1 + dur_w + voices * (1 + freq_w);
    endfunction

    function automatic int dur_lsb(input int voices, input int freq_w);
        return voices * (1 + freq_w);
    endfunction

    // Voice v occupies {gate, freq} with freq starting at this bit.
    function automatic int voice_lsb(input int v, input int freq_w);
        return v * (1 + freq_w);
    endfunction

endpackage

// File: rtl/seq_note_ram.sv
// rtl/seq_note_ram.sv - simple dual-port step RAM, synchronous read-first
module seq_note_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - programmable multi-voice note sequencer with gaps and looping
module music_sequencer
    import music_seq_pkg::*;
#(
    parameter int VOICES    = 2,
    parameter int DEPTH     = 32,
    parameter int FREQ_W    = 16,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 12500,
    parameter int GAP_TICKS = 1,
    parameter int ENTRY_W   = entry_w(VOICES, FREQ_W, DUR_W)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [ENTRY_W-1:0]       wr_data_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic                     busy_o,
    output logic [$clog2(DEPTH)-1:0] step_o,
    output logic                     done_o,
    output logic [VOICES-1:0]        voice_en_o,
    output logic [VOICES*FREQ_W-1:0] voice_freq_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TW      = $clog2(TICK_DIV);
    localparam int DUR_LSB = dur_lsb(VOICES, FREQ_W);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LEN   = DUR_W'(GAP_TICKS);

    seq_state_e               state_q;
    logic [AW-1:0]            step_q;
    logic [AW-1:0]            rd_addr_q;
    logic [TW-1:0]            tick_q;
    logic [DUR_W-1:0]         rem_q;
    logic [VOICES-1:0]        gate_q;
    logic [VOICES*FREQ_W-1:0] freq_q;
    logic                     last_q;
    logic                     gap_q;
    logic                     done_q;

    logic [ENTRY_W-1:0]       ram_rd_data;
    logic                     ent_last;
    logic                     ent_gap;
    logic [DUR_W-1:0]         ent_dur;
    logic [DUR_W-1:0]         ent_d;
    logic [DUR_W-1:0]         play_ticks;
    logic [VOICES-1:0]        ent_gate;
    logic [VOICES*FREQ_W-1:0] ent_freq;

    // rd_addr_q always holds the address of the next step to fetch, so the
    // read launched on the edge entering LOAD is ready to capture in LOAD.
    seq_note_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (ram_rd_data)
    );

    always_comb begin
        ent_gate = '0;
        ent_freq = '0;
        ent_last = ram_rd_data[ENTRY_W-1];
        ent_dur  = ram_rd_data[DUR_LSB +: DUR_W];
        for (int v = 0; v < VOICES; v++) begin
            ent_gate[v]                   = ram_rd_data[voice_lsb(v, FREQ_W) + FREQ_W];
            ent_freq[v*FREQ_W +: FREQ_W] = ram_rd_data[voice_lsb(v, FREQ_W) +: FREQ_W];
        end
        ent_d      = (ent_dur == '0) ? DUR_W'(1) : ent_dur;
        ent_gap    = (GAP_TICKS > 0) && (ent_d > GAP_LEN);
        play_ticks = ent_gap ? (ent_d - GAP_LEN) : ent_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            step_q    <= '0;
            rd_addr_q <= '0;
            tick_q    <= '0;
            rem_q     <= '0;
            gate_q    <= '0;
            freq_q    <= '0;
            last_q    <= 1'b0;
            gap_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop_i) begin
                state_q   <= IDLE;
                rd_addr_q <= '0;
                tick_q    <= '0;
                rem_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= LOAD;
                            step_q  <= rd_addr_q;
                            tick_q  <= '0;
                        end
                    end
                    LOAD: begin
                        state_q   <= PLAY;
                        gate_q    <= ent_gate;
                        freq_q    <= ent_freq;
                        last_q    <= ent_last;
                        gap_q     <= ent_gap;
                        rem_q     <= play_ticks;
                        rd_addr_q <= ent_last ? '0 : rd_addr_q + 1'b1;
                    end
                    default: begin
                        if (tick_q != TICK_LAST) begin
                            tick_q <= tick_q + 1'b1;
                        end else begin
                            tick_q <= '0;
                            if (rem_q > DUR_W'(1)) begin
                                rem_q <= rem_q - 1'b1;
                            end else if (state_q == PLAY && gap_q) begin
                                state_q <= GAP;
                                rem_q   <= GAP_LEN;
                            end else if (!last_q || loop_i) begin
                                state_q <= LOAD;
                                step_q  <= rd_addr_q;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign step_o       = step_q;
    assign done_o       = done_q;
    assign voice_en_o   = (state_q == PLAY) ? gate_q : '0;
    assign voice_freq_o = freq_q;

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - randomized and directed checks of music_sequencer against a timeline model
module tb_music_sequencer;

    localparam int TD    = 4;
    localparam int GAPT  = 1;
    localparam int DEPTH = 8;
    localparam int EW    = 43;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [EW-1:0] wr_data;
    logic          start, stop, loop;
    logic          busy, done;
    logic [2:0]    step;
    logic [1:0]    ven;
    logic [31:0]   vfreq;

    int tests = 0;
    int fails = 0;

    music_sequencer #(
        .VOICES(2), .DEPTH(DEPTH), .FREQ_W(16), .DUR_W(8),
        .TICK_DIV(TD), .GAP_TICKS(GAPT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .start_i(start), .stop_i(stop), .loop_i(loop),
        .busy_o(busy), .step_o(step), .done_o(done),
        .voice_en_o(ven), .voice_freq_o(vfreq)
    );

    always #5 clk = ~clk;

    // Timeline model: each step is LOAD (k=0), then d*TD clocks of which the
    // first play*TD are gated.
    logic [EW-1:0] mem_m [DEPTH];
    logic [EW-1:0] m_ent;
    bit            m_busy, m_done;
    int            m_k, m_addr;
    logic [1:0]    m_en;
    logic [31:0]   m_freq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur_of(input logic [EW-1:0] e);
        int d;
        d = int'(e[41:34]);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int play_of(input logic [EW-1:0] e);
        int d;
        d = dur_of(e);
        return (d > GAPT) ? d - GAPT : d;
    endfunction

    function automatic logic [EW-1:0] mk(input bit last, input int dur, input bit g0,
                                         input int f0, input bit g1, input int f1);
        return {last, 8'(dur), g1, 16'(f1), g0, 16'(f0)};
    endfunction

    function automatic logic [EW-1:0] rnd_entry();
        return mk(($urandom % 4) == 0, int'($urandom % 4), 1'($urandom), int'($urandom),
                  1'($urandom), int'($urandom));
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_k = 0; m_addr = 0; m_en = '0; m_freq = '0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (stop) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_k = 0; m_addr = 0; m_ent = mem_m[0];
            end
        end else begin
            m_k++;
            if (m_k == 1 + dur_of(m_ent) * TD) begin
                if (m_ent[EW-1] && !loop) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_addr = m_ent[EW-1] ? 0 : (m_addr + 1) % DEPTH;
                    m_k    = 0;
                    m_ent  = mem_m[m_addr];
                end
            end
        end
        if (m_busy && m_k == 1) m_freq = {m_ent[32:17], m_ent[15:0]};
        m_en = (m_busy && m_k >= 1 && m_k <= play_of(m_ent) * TD) ? {m_ent[33], m_ent[16]} : 2'b00;
        if (wr_en) mem_m[wr_addr] = wr_data;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("busy", 64'(busy), 64'(m_busy));
        check("voice_en", 64'(ven), 64'(m_en));
        check("voice_freq", 64'(vfreq), 64'(m_freq));
        check("step", 64'(step), 64'(m_addr));
        check("done", 64'(done), 64'(m_done));
        wr_en = 0; start = 0; stop = 0;
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        wr_en = 1; wr_addr = 3'(a); wr_data = d;
        cycle();
    endtask

    task automatic wait_model(input string tag, input int addr, input int k);
        int n;
        n = 0;
        while (!(m_busy && m_addr == addr && m_k == k) && n < 300) begin
            cycle();
            n++;
        end
        check(tag, 64'(n < 300), 64'(1));
    endtask

    initial begin
        int cnt_en, cnt_done, cnt_freq;
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop = 0; loop = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_en", 64'(ven), 64'(0));
        check("rst_freq", 64'(vfreq), 64'(0));
        check("rst_step", 64'(step), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 0;
        for (int i = 0; i < DEPTH; i++) wr(i, mk(0, 1, 0, 0, 0, 0));

        // Single step: 8 gated clocks at 4208, 4 gap clocks, then done.
        wr(0, mk(1, 3, 1, 4208, 0, 0));
        start = 1;
        cycle();
        cnt_en = 0; cnt_done = 0; cnt_freq = 0;
        repeat (16) begin
            cycle();
            if (ven == 2'b01) cnt_en++;
            if (done) cnt_done++;
            if (vfreq[15:0] == 16'd4208) cnt_freq++;
        end
        check("single_en_clocks", 64'(cnt_en), 64'(8));
        check("single_done_pulses", 64'(cnt_done), 64'(1));
        check("single_freq_clocks", 64'(cnt_freq), 64'(16));

        // Sequence with repeated 4208 notes, then reset mid-play.
        wr(0, mk(0, 2, 1, 3339, 1, 100));
        wr(1, mk(0, 2, 1, 5005, 0, 200));
        wr(2, mk(0, 2, 1, 4208, 1, 300));
        wr(3, mk(1, 2, 1, 4208, 1, 300));
        start = 1;
        repeat (45) cycle();
        start = 1;
        cycle();
        wait_model("wait_seq_play", 1, 3);
        @(negedge clk);
        rst = 1;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_en", 64'(ven), 64'(0));
        check("async_rst_freq", 64'(vfreq), 64'(0));
        check("async_rst_step", 64'(step), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        cycle();

        // Loop then stop: no done pulse.
        wr(0, mk(0, 1, 1, 11, 0, 0));
        wr(1, mk(1, 2, 0, 22, 1, 33));
        loop = 1; start = 1;
        cycle();
        cnt_done = 0;
        repeat (40) begin
            cycle();
            if (done) cnt_done++;
        end
        stop = 1;
        cycle();
        check("loop_no_done", 64'(cnt_done), 64'(0));
        loop = 0;

        // Start together with stop in IDLE.
        start = 1; stop = 1;
        cycle();
        cycle();

        // Wrap past DEPTH-1, dur=0 entry, start while busy.
        for (int i = 0; i < DEPTH; i++) wr(i, mk(0, (i == 3) ? 0 : 2, 1, 1000 + i, i % 2, 50 + i));
        start = 1;
        cycle();
        for (int i = 0; i < 80; i++) begin
            start = (i % 7) == 3;
            cycle();
        end
        stop = 1;
        cycle();

        // Rewrite entry 2 during step 1; collide a write with the fetch of entry 3.
        for (int i = 0; i < 4; i++) wr(i, mk(i == 3, 2, 1, 600 + i, 0, 0));
        start = 1;
        cycle();
        wait_model("wait_step1", 1, 3);
        wr(2, mk(0, 3, 0, 7777, 1, 8888));
        wait_model("wait_step2_end", 2, 3 * TD);
        wr(3, mk(1, 1, 1, 9999, 1, 9999));
        repeat (30) cycle();

        // Randomized traffic.
        for (int i = 0; i < DEPTH; i++) wr(i, rnd_entry());
        for (int i = 0; i < 2500; i++) begin
            if ($urandom % 6 == 0) begin
                wr_en = 1; wr_addr = 3'($urandom); wr_data = rnd_entry();
            end
            start = ($urandom % 10) == 0;
            stop  = ($urandom % 80) == 0;
            if ($urandom % 200 == 0) loop = ~loop;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
